vga_frame_scheduler: RTL



---
 rtl/vga_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/vga_frame_scheduler.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and scheduler state encoding for the frame scheduler.
package vga_pkg;

    localparam int unsigned H_TOTAL  = 800;
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_TOTAL  = 525;

    typedef logic [1:0] sched_state_t;

    localparam sched_state_t StIdle  = 2'd0;
    localparam sched_state_t StGrant = 2'd1;
    localparam sched_state_t StGap   = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible index strictly after ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N_REQ-1:0] pick_o,
    output logic [IW-1:0]    idx_o
);

    logic found;

    always_comb begin
        pick_o = '0;
        idx_o  = '0;
        found  = 1'b0;
        // Indices above the pointer first, then wrap around to the low indices.
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && eligible_i[i] && (IW'(i) > ptr_i)) begin
                found     = 1'b1;
                pick_o[i] = 1'b1;
                idx_o     = IW'(i);
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && eligible_i[i]) begin
                found     = 1'b1;
                pick_o[i] = 1'b1;
                idx_o     = IW'(i);
            end
        end
    end

endmodule

// File: rtl/vga_frame_scheduler.sv
// Grants shared frame/sprite state to one requester at a time, only during vertical blanking,
// so updates never tear the picture. Emits frame tick/counter and sticky timeout/overrun flags.
module vga_frame_scheduler #(
    parameter int unsigned N_REQ            = 4,
    parameter int unsigned V_ACTIVE         = vga_pkg::V_ACTIVE,
    parameter int unsigned V_TOTAL          = vga_pkg::V_TOTAL,
    parameter int unsigned GUARD_LINES      = 2,
    parameter int unsigned MAX_GRANT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       hor_count,
    input  logic [9:0]       ver_count,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] grant,
    output logic             frame_tick,
    output logic [7:0]       frame_count,
    output logic             window_open,
    output logic [N_REQ-1:0] timeout_flags,
    output logic [N_REQ-1:0] overrun_flags
);

    import vga_pkg::*;

    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned TW = (MAX_GRANT_CYCLES > 1) ? $clog2(MAX_GRANT_CYCLES) : 1;
    localparam logic [TW-1:0] TimerLast  = TW'(MAX_GRANT_CYCLES - 1);
    localparam logic [9:0]    VActive    = 10'(V_ACTIVE);
    localparam logic [9:0]    VGuard     = 10'(V_TOTAL - GUARD_LINES);

    logic             vb_q, vb_d;
    logic             tick_q, tick_d;
    logic [7:0]       fcount_q, fcount_d;
    logic             win_q, win_d;
    sched_state_t     state_q, state_d;
    logic [N_REQ-1:0] served_q, served_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] tflag_q, tflag_d;
    logic [N_REQ-1:0] oflag_q, oflag_d;

    logic             vb;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] pick;
    logic [IW-1:0]    pick_idx;
    logic             unused_hor;

    // Horizontal position is not needed; blanking is tracked per line.
    assign unused_hor = ^hor_count;

    assign vb       = (ver_count >= VActive);
    assign eligible = req & ~served_q;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_arbiter (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .pick_o     (pick),
        .idx_o      (pick_idx)
    );

    always_comb begin
        vb_d     = vb;
        tick_d   = vb & ~vb_q;
        fcount_d = fcount_q + {7'd0, tick_q};
        win_d    = win_q;
        state_d  = state_q;
        served_d = served_q;
        ptr_d    = ptr_q;
        timer_d  = timer_q;
        grant_d  = grant_q;
        tflag_d  = tflag_q;
        oflag_d  = oflag_q;

        if ((ver_count >= VGuard) || !vb) begin
            win_d = 1'b0;
        end else if (tick_q) begin
            win_d = 1'b1;
        end

        if (tick_q) begin
            served_d = '0;
        end

        case (state_q)
            StIdle: begin
                if (win_q && (|eligible)) begin
                    grant_d = pick;
                    ptr_d   = pick_idx;
                    timer_d = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                timer_d = timer_q + 1'b1;
                // done beats timeout, timeout beats overrun; window closing never revokes.
                if (|(done & grant_q)) begin
                    grant_d  = '0;
                    served_d = served_d | grant_q;
                    state_d  = StGap;
                end else if (timer_q == TimerLast) begin
                    grant_d  = '0;
                    served_d = served_d | grant_q;
                    tflag_d  = tflag_q | grant_q;
                    state_d  = StGap;
                end else if (!vb) begin
                    grant_d  = '0;
                    served_d = served_d | grant_q;
                    oflag_d  = oflag_q | grant_q;
                    state_d  = StGap;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                grant_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vb_q     <= 1'b0;
            tick_q   <= 1'b0;
            fcount_q <= '0;
            win_q    <= 1'b0;
            state_q  <= StIdle;
            served_q <= '0;
            ptr_q    <= IW'(N_REQ - 1);
            timer_q  <= '0;
            grant_q  <= '0;
            tflag_q  <= '0;
            oflag_q  <= '0;
        end else begin
            vb_q     <= vb_d;
            tick_q   <= tick_d;
            fcount_q <= fcount_d;
            win_q    <= win_d;
            state_q  <= state_d;
            served_q <= served_d;
            ptr_q    <= ptr_d;
            timer_q  <= timer_d;
            grant_q  <= grant_d;
            tflag_q  <= tflag_d;
            oflag_q  <= oflag_d;
        end
    end

    assign grant         = grant_q;
    assign frame_tick    = tick_q;
    assign frame_count   = fcount_q;
    assign window_open   = win_q;
    assign timeout_flags = tflag_q;
    assign overrun_flags = oflag_q;

endmodule
